// File: rtl/ntt_ctrl_pkg.sv
// Shared control-path definitions for the NTT sequencers.
`ifndef DEGREE
`define DEGREE 256
`endif
`ifndef RADIX_K1
`define RADIX_K1 1
`endif
`ifndef RADIX_K2
`define RADIX_K2 1
`endif
`ifndef D_width
`define D_width 64
`endif

package ntt_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FLUSH,
    DONE
  } tf_seq_state_t;

  localparam int unsigned STAGE_NUM_DEF = ($clog2(`DEGREE) - `RADIX_K2) / `RADIX_K1 + 1;
  localparam int unsigned D_WIDTH_DEF   = `D_width;

  // Bits needed to hold 0..range-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/stall_counter.sv
// Loadable up-counter with enable, synchronous clear and terminal-count flag.
module stall_counter
   import ntt_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MAX   = 15
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Next count: clear beats load beats increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == WIDTH'(MAX));

endmodule

// File: rtl/tf_seq_ctrl.sv
// Twiddle-factor sequencer: init pulse, per-stage iteration walk, pipeline drain, done.
module tf_seq_ctrl
   import ntt_ctrl_pkg::*;
#(
   parameter int unsigned D_WIDTH   = 64,
   parameter int unsigned STAGE_NUM = 4,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned PIPE_LAT  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stall,
   input  logic               abort,
   output logic               TF_init_base,
   output logic               TF_init_const,
   output logic               TF_ren,
   output logic               TF_wen,
   output logic [D_WIDTH-1:0] it_depth_cnt,
   output logic [D_WIDTH-1:0] l,
   output logic               LAST_STAGE,
   output logic               busy,
   output logic               done
);

   localparam int unsigned IT_W = cnt_width(DEPTH);
   localparam int unsigned DR_W = cnt_width(PIPE_LAT);
   localparam int unsigned L_W  = cnt_width(STAGE_NUM);
   localparam logic [L_W-1:0] L_LAST = L_W'(STAGE_NUM - 1);
   localparam int unsigned DR_MAX = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

   tf_seq_state_t    state_q, state_d;
   logic [L_W-1:0]   l_q, l_d, l_inc;
   logic             init_q, init_d;
   logic             ren_q, ren_d;
   logic             wen_q, wen_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             adv;
   logic             it_clr, it_en, it_tc;
   logic [IT_W-1:0]  it_cnt;
   logic             dr_clr, dr_en, dr_tc;
   logic [DR_W-1:0]  dr_cnt;
   logic             unused_dr;

   // Iteration index within the current stage; holds at DEPTH-1 while draining.
   stall_counter #(
      .WIDTH (IT_W),
      .MAX   (DEPTH - 1)
   ) u_it_cnt (
      .clk_i      (clk),
      .rst_ni     (rst),
      .clr_i      (it_clr),
      .load_i     (1'b0),
      .load_val_i ('0),
      .en_i       (it_en),
      .cnt_o      (it_cnt),
      .tc_o       (it_tc)
   );

   // Drain counter: zero on entry to FLUSH, stops at its terminal count.
   stall_counter #(
      .WIDTH (DR_W),
      .MAX   (DR_MAX)
   ) u_dr_cnt (
      .clk_i      (clk),
      .rst_ni     (rst),
      .clr_i      (dr_clr),
      .load_i     (1'b0),
      .load_val_i ('0),
      .en_i       (dr_en),
      .cnt_o      (dr_cnt),
      .tc_o       (dr_tc)
   );

   assign dr_clr    = (state_q != FLUSH);
   assign dr_en     = (state_q == FLUSH) && !dr_tc;
   assign unused_dr = ^dr_cnt;

   // Next state and next registered outputs. Outputs for the coming cycle are
   // decided here, so a RUN cycle's ren/wen reflect stall sampled at its opening edge.
   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      last_d  = last_q;
      init_d  = 1'b0;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
      it_clr  = 1'b0;
      it_en   = 1'b0;
      adv     = 1'b0;
      l_inc   = l_q + L_W'(1);

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start && !abort) begin
               state_d = INIT;
               init_d  = 1'b1;
               busy_d  = 1'b1;
               last_d  = (STAGE_NUM == 1);
               it_clr  = 1'b1;
            end
         end
         INIT: begin
            state_d = RUN;
            ren_d   = !stall;
            wen_d   = !stall && !last_q;
         end
         RUN: begin
            ren_d = !stall;
            wen_d = !stall && !last_q;
            if (ren_q) begin
               if (it_tc) begin
                  ren_d = 1'b0;
                  wen_d = 1'b0;
                  if (PIPE_LAT == 0) begin
                     adv = 1'b1;
                  end else begin
                     state_d = FLUSH;
                  end
               end else begin
                  it_en = 1'b1;
               end
            end
         end
         FLUSH: begin
            adv = dr_tc;
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Stage boundary: next stage straight into RUN, or finish.
      if (adv) begin
         it_clr = 1'b1;
         if (l_q != L_LAST) begin
            state_d = RUN;
            l_d     = l_inc;
            last_d  = (l_inc == L_LAST);
            ren_d   = !stall;
            wen_d   = !stall && (l_inc != L_LAST);
         end else begin
            state_d = DONE;
            done_d  = 1'b1;
            l_d     = '0;
            last_d  = 1'b0;
         end
      end

      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         l_d     = '0;
         last_d  = 1'b0;
         init_d  = 1'b0;
         ren_d   = 1'b0;
         wen_d   = 1'b0;
         done_d  = 1'b0;
         busy_d  = 1'b0;
         it_clr  = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         l_q     <= '0;
         init_q  <= 1'b0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         init_q  <= init_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign TF_init_base  = init_q;
   assign TF_init_const = init_q;
   assign TF_ren        = ren_q;
   assign TF_wen        = wen_q;
   assign LAST_STAGE    = last_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign l             = D_WIDTH'(l_q);
   assign it_depth_cnt  = D_WIDTH'(it_cnt);

endmodule

// File: doc/tf_seq_ctrl.md
Name: tf_seq_ctrl

Overview:
- Sequencer directly upstream of the twiddle-factor top block (TF_top / TF_gen); drives all of its control inputs.
- Per NTT run: pulses base/constant init, then walks stage index l and per-stage iteration counter it_depth_cnt.
- Issues TF_ren/TF_wen per iteration, drains the TF pipeline between stages, and flags the final (radix_k2) stage with LAST_STAGE.
- Reports busy/done to the NTT top controller.

Parameters:
- D_WIDTH, 64, width of l and it_depth_cnt (equals `D_width).
- STAGE_NUM, 4, total stages including the final radix_k2 stage; legal range 1..255.
- DEPTH, 256, iterations per stage; legal range 1..2^16.
- PIPE_LAT, 3, drain cycles after each stage's last iteration; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- stall  in  1  freezes iteration progress while high.
- abort  in  1  synchronous return to IDLE from any state.
- TF_init_base  out  1  registered one-cycle init pulse.
- TF_init_const  out  1  registered one-cycle init pulse.
- TF_ren  out  1  twiddle read enable.
- TF_wen  out  1  twiddle base write-back enable.
- it_depth_cnt  out  D_WIDTH  iteration index within the current stage.
- l  out  D_WIDTH  stage index.
- LAST_STAGE  out  1  high while l == STAGE_NUM-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; every output 0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, INIT, RUN, FLUSH, DONE.
- IDLE:
  - Outputs idle.
  - start=1 -> INIT.
- INIT: exactly one cycle.
  - TF_init_base=1, TF_init_const=1, l=0, it_depth_cnt=0.
  - -> RUN.
- RUN:
  - stall=0: TF_ren=1, TF_wen=!LAST_STAGE, it_depth_cnt is valid for this cycle.
  - stall=1: TF_ren=TF_wen=0; it_depth_cnt holds; the iteration is not consumed.
  - On a non-stalled cycle with it_depth_cnt==DEPTH-1 -> FLUSH (or directly to next stage/DONE if PIPE_LAT=0).
  - Otherwise it_depth_cnt++.
- FLUSH:
  - TF_ren=TF_wen=0; the drain counter counts PIPE_LAT cycles.
  - stall does not affect the drain.
  - On the last drain cycle, if l<STAGE_NUM-1: l++, it_depth_cnt=0, LAST_STAGE = (new l == STAGE_NUM-1), -> RUN.
  - Otherwise -> DONE.
- DONE: done=1 for one cycle, l and it_depth_cnt cleared, LAST_STAGE=0, -> IDLE.
- STAGE_NUM=1: LAST_STAGE is set in INIT, so the only stage runs with TF_wen=0.
- start outside IDLE is ignored; there is no queuing.
- abort has priority over all transitions:
  - Next state is IDLE with all outputs 0.
  - done is not pulsed.
  - abort in IDLE has no effect.
- start and abort high together in IDLE: stay in IDLE.
- Counter width: internal counters are sized by $clog2 of their range. l and it_depth_cnt are zero-extended to D_WIDTH. No wrap occurs within legal parameters.
- Total latency with no stall: start sampled at edge N; done is high in cycle N+2+STAGE_NUM*(DEPTH+PIPE_LAT).

Decomposition:
- Shared package ntt_ctrl_pkg holds:
  - enum tf_seq_state_t {IDLE, INIT, RUN, FLUSH, DONE};
  - localparams derived from `degree/`radix_k1/`radix_k2, specifically STAGE_NUM_DEF = ($clog2(`degree) - `radix_k2)/`radix_k1 + 1.
- One natural sub-module, stall_counter: a loadable up-counter with enable, terminal-count flag and sync clear. Instantiate it twice, once for the iteration counter and once for the drain counter.

Test Plan (STAGE_NUM=3, DEPTH=4, PIPE_LAT=2 unless noted):
- Reset/idle: rst low mid-RUN at l=1 -> all outputs 0 immediately, without waiting for a clk edge; after release, state is IDLE and busy=0.
- Nominal run: start pulse at edge 0:
  - Cycle 1: init pulses high.
  - TF_ren high in cycles 2-5, 8-11, 14-17, with it_depth_cnt 0,1,2,3 each stage.
  - l = 0/1/2.
  - LAST_STAGE high in cycles 14-19; TF_wen low in 14-17.
  - done in cycle 20; busy high for cycles 1-20.
- Stall: stall held high for cycles 3-4 of stage 0 -> it_depth_cnt holds at 1 with TF_ren=0; stage 0 ends in cycle 7; done moves to cycle 22.
- Abort: abort at cycle 9 -> cycle 10 is IDLE with busy=0, l=0, and no done pulse; a new start then runs the nominal sequence.
- Edge parameters: STAGE_NUM=1, DEPTH=1, PIPE_LAT=0:
  - Cycle 1: INIT with LAST_STAGE=1.
  - Cycle 2: TF_ren=1, TF_wen=0.
  - Cycle 3: done.
- Start while busy: start pulse at cycle 5 -> ignored; sequence timing is identical to the nominal run.
